sprite_blitter: RTL

//  Copies one rectangular sprite from CharacterRam (8-bit indexed, palette-decoded to 24-bit RGB) into

---
 rtl/gfx_pkg.sv | 47 ++++
 rtl/blit_clip_addr.sv | 37 +++
 rtl/sprite_blitter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/gfx_pkg.sv
// gfx_pkg: shared graphics definitions for the sprite blitter slice.
//  - Screen geometry (FB_W x FB_H), transparent key colour, RAM address width.
//  - rgb_t pixel type, blit_state_t FSM encoding, blit_cmd_t latched command.
//  - texel_addr(): CharacterRam address of one texel within the current sheet row.
package gfx_pkg;

   localparam int          FB_W      = 240;
   localparam int          FB_H      = 160;
   localparam int          ADDR_W    = 19;
   localparam logic [23:0] KEY_COLOR = 24'hFF00FF;

   typedef logic [23:0] rgb_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } blit_state_t;

   // src_base is not kept here: it seeds the row-base accumulator at accept time.
   typedef struct packed {
      logic [8:0] src_stride;
      logic [5:0] spr_w;
      logic [5:0] spr_h;
      logic [9:0] dst_x;
      logic [9:0] dst_y;
      logic       flip_h;
   } blit_cmd_t;

   // Texel address: row base plus column offset, mirrored when flip is set.
   function automatic logic [ADDR_W-1:0] texel_addr(
      input logic [ADDR_W-1:0] row_base,
      input logic [5:0]        col,
      input logic [5:0]        width,
      input logic              flip
   );
      logic [5:0] offset;
      if (flip) begin
         offset = width - 6'd1 - col;
      end else begin
         offset = col;
      end
      return row_base + {{(ADDR_W-6){1'b0}}, offset};
   endfunction

endpackage

// File: rtl/blit_clip_addr.sv
// blit_clip_addr: combinational screen clipping and framebuffer addressing.
//  Ports:
//   dst_x, dst_y  in  10  signed sprite origin on screen
//   col, row      in  6   texel position inside the sprite
//   in_bounds     out 1   screen pixel lies inside the FB_W x FB_H area
//   fb_addr       out 19  sy*FB_W + sx when in_bounds, otherwise 0
module blit_clip_addr
   import gfx_pkg::*;
(
   input  logic [9:0]        dst_x,
   input  logic [9:0]        dst_y,
   input  logic [5:0]        col,
   input  logic [5:0]        row,
   output logic              in_bounds,
   output logic [ADDR_W-1:0] fb_addr
);

   logic signed [10:0] sx_s;
   logic signed [10:0] sy_s;

   // 11 bits hold -512..574, so origin + offset can never wrap.
   assign sx_s = $signed({dst_x[9], dst_x}) + $signed({5'b00000, col});
   assign sy_s = $signed({dst_y[9], dst_y}) + $signed({5'b00000, row});

   // Bounds test and linear address; the address is forced to 0 off-screen.
   always_comb begin
      in_bounds = (sx_s[10] == 1'b0) && (sx_s[9:0] < 10'(FB_W)) &&
                  (sy_s[10] == 1'b0) && (sy_s[9:0] < 10'(FB_H));
      if (in_bounds) begin
         // In bounds guarantees sx < 240 and sy < 160, so 8 bits of each suffice.
         fb_addr = {11'd0, sy_s[7:0]} * 19'(FB_W) + {11'd0, sx_s[7:0]};
      end else begin
         fb_addr = {ADDR_W{1'b0}};
      end
   end

endmodule

// File: rtl/sprite_blitter.sv
// sprite_blitter: copies one sprite from CharacterRam to FramebufferRam.
//  Ports:
//   Clk, Reset          clock, synchronous active-high reset
//   start               command strobe, taken only while idle
//   src_base/src_stride sheet address of the top-left texel / sheet row pitch
//   spr_w/spr_h         sprite size (0 means nothing to draw)
//   dst_x/dst_y         signed screen origin; flip_h mirrors horizontally
//   busy, done          command in progress / one-cycle completion pulse
//   char_addr/char_data CharacterRam read port (data one cycle after address)
//   fb_addr/fb_data/fb_we FramebufferRam write port
//  One texel is issued per cycle; its write slot follows one cycle later, aligned
//  with the returning char_data. Transparent (KEY_COLOR) and off-screen pixels skip.
module sprite_blitter
   import gfx_pkg::*;
(
   input  logic              Clk,
   input  logic              Reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_base,
   input  logic [8:0]        src_stride,
   input  logic [5:0]        spr_w,
   input  logic [5:0]        spr_h,
   input  logic [9:0]        dst_x,
   input  logic [9:0]        dst_y,
   input  logic              flip_h,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] char_addr,
   input  rgb_t              char_data,
   output logic [ADDR_W-1:0] fb_addr,
   output rgb_t              fb_data,
   output logic              fb_we
);

   blit_state_t       state_r;
   blit_state_t       next_state_s;
   blit_cmd_t         cmd_r;
   logic [5:0]        col_r;
   logic [5:0]        row_r;
   logic [ADDR_W-1:0] row_base_r;
   logic [ADDR_W-1:0] next_row_base_s;
   logic [ADDR_W-1:0] char_addr_r;
   logic              s1_valid_r;
   logic              s1_in_bounds_r;
   logic [ADDR_W-1:0] s1_addr_r;
   logic              busy_r;
   logic              done_r;
   logic              clip_in_bounds_s;
   logic [ADDR_W-1:0] clip_addr_s;
   logic              accept_s;
   logic              empty_s;
   logic              last_col_s;
   logic              last_s;

   assign accept_s        = (state_r == IDLE) && start;
   assign empty_s         = (spr_w == 6'd0) || (spr_h == 6'd0);
   assign last_col_s      = (col_r == cmd_r.spr_w - 6'd1);
   assign last_s          = last_col_s && (row_r == cmd_r.spr_h - 6'd1);
   assign next_row_base_s = row_base_r + {{(ADDR_W-9){1'b0}}, cmd_r.src_stride};

   // Clip/address the texel currently presented on char_addr.
   blit_clip_addr u_clip (
      .dst_x     (cmd_r.dst_x),
      .dst_y     (cmd_r.dst_y),
      .col       (col_r),
      .row       (row_r),
      .in_bounds (clip_in_bounds_s),
      .fb_addr   (clip_addr_s)
   );

   // Next-state decode for the blit sequencer.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               if (empty_s) begin
                  next_state_s = DONE;
               end else begin
                  next_state_s = RUN;
               end
            end else begin
               next_state_s = IDLE;
            end
         end
         RUN: begin
            if (last_s) begin
               next_state_s = DRAIN;
            end else begin
               next_state_s = RUN;
            end
         end
         DRAIN:   next_state_s = DONE;
         DONE:    next_state_s = IDLE;
         default: next_state_s = IDLE;
      endcase
   end

   // State register with busy/done registered from the next state.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_r <= IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= next_state_s;
         busy_r  <= (next_state_s != IDLE);
         done_r  <= (next_state_s == DONE);
      end
   end

   // Command latch, col/row walk and source address accumulator.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         cmd_r       <= '0;
         col_r       <= 6'd0;
         row_r       <= 6'd0;
         row_base_r  <= {ADDR_W{1'b0}};
         char_addr_r <= {ADDR_W{1'b0}};
      end else if (accept_s) begin
         cmd_r      <= '{src_stride: src_stride, spr_w: spr_w, spr_h: spr_h,
                         dst_x: dst_x, dst_y: dst_y, flip_h: flip_h};
         col_r      <= 6'd0;
         row_r      <= 6'd0;
         row_base_r <= src_base;
         // An empty sprite leaves the read port untouched.
         if (!empty_s) begin
            char_addr_r <= texel_addr(src_base, 6'd0, spr_w, flip_h);
         end
      end else if ((state_r == RUN) && !last_s) begin
         if (last_col_s) begin
            col_r       <= 6'd0;
            row_r       <= row_r + 6'd1;
            row_base_r  <= next_row_base_s;
            char_addr_r <= texel_addr(next_row_base_s, 6'd0, cmd_r.spr_w, cmd_r.flip_h);
         end else begin
            col_r       <= col_r + 6'd1;
            char_addr_r <= texel_addr(row_base_r, col_r + 6'd1, cmd_r.spr_w, cmd_r.flip_h);
         end
      end
   end

   // Stage-1: carries the issued texel's write decision to the cycle its data returns.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         s1_valid_r     <= 1'b0;
         s1_in_bounds_r <= 1'b0;
         s1_addr_r      <= {ADDR_W{1'b0}};
      end else begin
         s1_valid_r <= (state_r == RUN);
         if (state_r == RUN) begin
            s1_in_bounds_r <= clip_in_bounds_s;
            s1_addr_r      <= clip_addr_s;
         end
      end
   end

   assign busy      = busy_r;
   assign done      = done_r;
   assign char_addr = char_addr_r;
   assign fb_addr   = s1_addr_r;
   assign fb_data   = s1_valid_r ? char_data : 24'h000000;
   assign fb_we     = s1_valid_r && s1_in_bounds_r && (char_data != KEY_COLOR);

endmodule
